// File: rtl/instruction_decode.sv
// instruction_decode: RV32I ID stage with register file, immediate generation, load-use stall and ID_EX register.
// Rev 1.0
`default_nettype none

module instruction_decode #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     ifIdInstruction,
  input  logic [XLEN-1:0] ifIdNpc,
  input  logic            flush,
  input  logic            wbRegWrite,
  input  logic [4:0]      wbRd,
  input  logic [XLEN-1:0] wbData,
  output logic            stall,
  output logic [XLEN-1:0] idExNpc,
  output logic [XLEN-1:0] idExRs1Data,
  output logic [XLEN-1:0] idExRs2Data,
  output logic [XLEN-1:0] idExImm,
  output logic [4:0]      idExRs1,
  output logic [4:0]      idExRs2,
  output logic [4:0]      idExRd,
  output logic [2:0]      idExFunct3,
  output logic            idExFunct7b5,
  output logic [1:0]      idExAluOp,
  output logic            idExAluSrc,
  output logic            idExRegWrite,
  output logic            idExMemRead,
  output logic            idExMemWrite,
  output logic            idExBranch,
  output logic            idExMemToReg
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  logic [XLEN-1:0] regs [NREGS];

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic [XLEN-1:0] imm;
  logic [1:0]      alu_op;
  logic            alu_src, reg_write, mem_read, mem_write, branch, mem_to_reg;
  logic            use_rs1, use_rs2, hazard;

  assign opcode = ifIdInstruction[6:0];
  assign rd     = ifIdInstruction[11:7];
  assign rs1    = ifIdInstruction[19:15];
  assign rs2    = ifIdInstruction[24:20];

  always_comb begin
    imm        = '0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    mem_to_reg = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b11;
        use_rs1   = 1'b1;
        imm       = {{(XLEN-12){ifIdInstruction[31]}}, ifIdInstruction[31:20]};
      end
      OP_LD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        use_rs1    = 1'b1;
        imm        = {{(XLEN-12){ifIdInstruction[31]}}, ifIdInstruction[31:20]};
      end
      OP_ST: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        imm       = {{(XLEN-12){ifIdInstruction[31]}}, ifIdInstruction[31:25],
                     ifIdInstruction[11:7]};
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_op  = 2'b01;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = {{(XLEN-13){ifIdInstruction[31]}}, ifIdInstruction[31], ifIdInstruction[7],
                   ifIdInstruction[30:25], ifIdInstruction[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // Write-first bypass so a same-cycle writeback is seen by the decoding instruction.
  assign rs1_data = (rs1 == 5'd0) ? '0 :
                    (wbRegWrite && wbRd == rs1) ? wbData : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 :
                    (wbRegWrite && wbRd == rs2) ? wbData : regs[rs2];

  assign hazard = idExMemRead && (idExRd != 5'd0) &&
                  ((use_rs1 && rs1 == idExRd) || (use_rs2 && rs2 == idExRd));
  assign stall  = hazard && !flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      idExNpc      <= '0;
      idExRs1Data  <= '0;
      idExRs2Data  <= '0;
      idExImm      <= '0;
      idExRs1      <= '0;
      idExRs2      <= '0;
      idExRd       <= '0;
      idExFunct3   <= '0;
      idExFunct7b5 <= 1'b0;
      idExAluOp    <= '0;
      idExAluSrc   <= 1'b0;
      idExRegWrite <= 1'b0;
      idExMemRead  <= 1'b0;
      idExMemWrite <= 1'b0;
      idExBranch   <= 1'b0;
      idExMemToReg <= 1'b0;
    end else begin
      if (wbRegWrite && wbRd != 5'd0) regs[wbRd] <= wbData;
      if (flush || stall) begin
        idExNpc      <= '0;
        idExRs1Data  <= '0;
        idExRs2Data  <= '0;
        idExImm      <= '0;
        idExRs1      <= '0;
        idExRs2      <= '0;
        idExRd       <= '0;
        idExFunct3   <= '0;
        idExFunct7b5 <= 1'b0;
        idExAluOp    <= '0;
        idExAluSrc   <= 1'b0;
        idExRegWrite <= 1'b0;
        idExMemRead  <= 1'b0;
        idExMemWrite <= 1'b0;
        idExBranch   <= 1'b0;
        idExMemToReg <= 1'b0;
      end else begin
        idExNpc      <= ifIdNpc;
        idExRs1Data  <= rs1_data;
        idExRs2Data  <= rs2_data;
        idExImm      <= imm;
        idExRs1      <= rs1;
        idExRs2      <= rs2;
        idExRd       <= rd;
        idExFunct3   <= ifIdInstruction[14:12];
        idExFunct7b5 <= ifIdInstruction[30];
        idExAluOp    <= alu_op;
        idExAluSrc   <= alu_src;
        idExRegWrite <= reg_write;
        idExMemRead  <= mem_read;
        idExMemWrite <= mem_write;
        idExBranch   <= branch;
        idExMemToReg <= mem_to_reg;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode.sv
// tb_instruction_decode: directed scoreboard bench for the ID stage.
`default_nettype none

module tb_instruction_decode;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7b5;
    logic [1:0]  aluop;
    logic [5:0]  ctrl;  // {alusrc, regwrite, memread, memwrite, branch, memtoreg}
  } exp_t;

  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_R    = 6'b010000;
  localparam logic [5:0] C_I    = 6'b110000;
  localparam logic [5:0] C_LD   = 6'b111001;
  localparam logic [5:0] C_ST   = 6'b100100;
  localparam logic [5:0] C_BR   = 6'b000010;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr, npc, wb_data;
  logic        flush, wb_we;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] ex_npc, ex_rs1d, ex_rs2d, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_f3;
  logic        ex_f7b5;
  logic [1:0]  ex_aluop;
  logic        ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_memtoreg;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t obs;
  exp_t zero_e;

  always #5 clock = ~clock;

  instruction_decode dut (
    .clock(clock), .reset(reset), .ifIdInstruction(instr), .ifIdNpc(npc),
    .flush(flush), .wbRegWrite(wb_we), .wbRd(wb_rd), .wbData(wb_data),
    .stall(stall), .idExNpc(ex_npc), .idExRs1Data(ex_rs1d), .idExRs2Data(ex_rs2d),
    .idExImm(ex_imm), .idExRs1(ex_rs1), .idExRs2(ex_rs2), .idExRd(ex_rd),
    .idExFunct3(ex_f3), .idExFunct7b5(ex_f7b5), .idExAluOp(ex_aluop),
    .idExAluSrc(ex_alusrc), .idExRegWrite(ex_regwrite), .idExMemRead(ex_memread),
    .idExMemWrite(ex_memwrite), .idExBranch(ex_branch), .idExMemToReg(ex_memtoreg)
  );

  assign obs = {ex_npc, ex_rs1d, ex_rs2d, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_f3, ex_f7b5,
                ex_aluop, ex_alusrc, ex_regwrite, ex_memread, ex_memwrite, ex_branch,
                ex_memtoreg};

  function automatic logic [31:0] enc_r(logic [4:0] rs2, logic [4:0] rs1, logic [4:0] rd);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {im, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] im, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic exp_t mk(logic [31:0] n, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] im, logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                              logic [2:0] f3, logic f7, logic [1:0] op, logic [5:0] c);
    exp_t e;
    e.npc = n; e.rs1d = d1; e.rs2d = d2; e.imm = im;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.f3 = f3; e.f7b5 = f7;
    e.aluop = op; e.ctrl = c;
    return e;
  endfunction

  task automatic cmp(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic cmp_all(string tag, exp_t e);
    cmp({tag, ".npc"},   obs.npc,  e.npc);
    cmp({tag, ".rs1d"},  obs.rs1d, e.rs1d);
    cmp({tag, ".rs2d"},  obs.rs2d, e.rs2d);
    cmp({tag, ".imm"},   obs.imm,  e.imm);
    cmp({tag, ".idx"},   {17'b0, obs.rs1, obs.rs2, obs.rd}, {17'b0, e.rs1, e.rs2, e.rd});
    cmp({tag, ".funct"}, {28'b0, obs.f3, obs.f7b5}, {28'b0, e.f3, e.f7b5});
    cmp({tag, ".ctrl"},  {24'b0, obs.aluop, obs.ctrl}, {24'b0, e.aluop, e.ctrl});
  endtask

  task automatic step(string tag, logic [31:0] ins, logic [31:0] pc, logic fl, logic we,
                      logic [4:0] wrd, logic [31:0] wd, logic exp_stall, exp_t e);
    instr = ins; npc = pc; flush = fl; wb_we = we; wb_rd = wrd; wb_data = wd;
    #1;
    cmp({tag, ".stall"}, {31'b0, stall}, {31'b0, exp_stall});
    q.push_back(e);
    @(posedge clock);
    #1;
    cmp_all(tag, q.pop_front());
  endtask

  initial begin
    zero_e = '0;
    reset = 1'b0; instr = '0; npc = '0; flush = 1'b0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clock);
    #1;
    cmp_all("reset", zero_e);
    reset = 1'b1;

    // Unknown opcode 0 while writing x5; then add x6,x5,x0 sees the written value.
    step("wb_x5", 32'h0, 32'h100, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0,
         mk(32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, C_NONE));
    step("add_x6", enc_r(5'd0, 5'd5, 5'd6), 32'h104, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         mk(32'h104, 32'hDEADBEEF, 0, 0, 5'd5, 5'd0, 5'd6, 0, 0, 2'b10, C_R));

    // Same-cycle writeback bypass into addi.
    step("addi_x8", enc_i(12'hFFF, 5'd7, 3'd0, 5'd8, 7'b0010011), 32'h108, 1'b0, 1'b1,
         5'd7, 32'h1234, 1'b0,
         mk(32'h108, 32'h1234, 0, 32'hFFFFFFFF, 5'd7, 5'd31, 5'd8, 0, 1'b1, 2'b11, C_I));

    // Load-use: one stall cycle, bubble, then the add decodes.
    step("lw_x9", enc_i(12'h0, 5'd1, 3'd2, 5'd9, 7'b0000011), 32'h10C, 1'b0, 1'b1,
         5'd2, 32'h22, 1'b0,
         mk(32'h10C, 0, 0, 0, 5'd1, 5'd0, 5'd9, 3'd2, 0, 2'b00, C_LD));
    step("lu_stall", enc_r(5'd2, 5'd9, 5'd10), 32'h110, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1,
         zero_e);
    step("lu_add", enc_r(5'd2, 5'd9, 5'd10), 32'h110, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         mk(32'h110, 0, 32'h22, 0, 5'd9, 5'd2, 5'd10, 0, 0, 2'b10, C_R));

    // Flush overrides the load-use stall.
    step("lw2_x9", enc_i(12'h0, 5'd1, 3'd2, 5'd9, 7'b0000011), 32'h114, 1'b0, 1'b0,
         5'd0, 32'h0, 1'b0,
         mk(32'h114, 0, 0, 0, 5'd1, 5'd0, 5'd9, 3'd2, 0, 2'b00, C_LD));
    step("flush", enc_r(5'd2, 5'd9, 5'd10), 32'h118, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0,
         zero_e);

    // Writes to x0 are dropped and not bypassed.
    step("wb_x0", enc_r(5'd0, 5'd0, 5'd11), 32'h11C, 1'b0, 1'b1, 5'd0, 32'hFFFF, 1'b0,
         mk(32'h11C, 0, 0, 0, 0, 0, 5'd11, 0, 0, 2'b10, C_R));
    step("beq", enc_b(13'h1FF8, 5'd7, 5'd0, 3'd0), 32'h120, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         mk(32'h120, 0, 32'h1234, 32'hFFFFFFF8, 5'd0, 5'd7, 5'd25, 0, 1'b1, 2'b01, C_BR));
    step("sw", enc_s(12'hFFC, 5'd2, 5'd7, 3'd2), 32'h124, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         mk(32'h124, 32'h1234, 32'h22, 32'hFFFFFFFC, 5'd7, 5'd2, 5'd28, 3'd2, 1'b1,
            2'b00, C_ST));

    // Reset asserted mid-stall between edges.
    step("lw3_x9", enc_i(12'h0, 5'd1, 3'd2, 5'd9, 7'b0000011), 32'h128, 1'b0, 1'b0,
         5'd0, 32'h0, 1'b0,
         mk(32'h128, 0, 0, 0, 5'd1, 5'd0, 5'd9, 3'd2, 0, 2'b00, C_LD));
    instr = enc_r(5'd2, 5'd9, 5'd10); npc = 32'h12C;
    #1;
    cmp("pre_rst.stall", {31'b0, stall}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    cmp_all("mid_rst", zero_e);
    cmp("mid_rst.stall", {31'b0, stall}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    cmp("post_rst.stall", {31'b0, stall}, 32'd0);

    // Register file cleared by reset; write x31 for the next read.
    step("post_rst_add", enc_r(5'd2, 5'd9, 5'd10), 32'h12C, 1'b0, 1'b1, 5'd31,
         32'h0000A5A5, 1'b0,
         mk(32'h12C, 0, 0, 0, 5'd9, 5'd2, 5'd10, 0, 0, 2'b10, C_R));
    step("op_7f", 32'hFFFFFFFF, 32'h130, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0,
         mk(32'h130, 32'hA5A5, 32'hA5A5, 0, 5'd31, 5'd31, 5'd31, 3'd7, 1'b1, 2'b00, C_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
